// File: rtl/h_pkg.sv
// Shared definitions for the engine command decoder: micro-op kinds,
// header field layout and FSM state encodings.
package h_pkg;

  typedef enum logic [1:0] {
    UOP_HDR  = 2'd0,
    UOP_DATA = 2'd1,
    UOP_ERR  = 2'd2
  } uop_kind_e;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_PAYLOAD = 2'd1;
  localparam logic [1:0] ST_DRAIN   = 2'd2;

  // header = {opc, len, imm, rsvd}; rsvd bits are never looked at
  localparam int OPC_LSB = 28;
  localparam int OPC_W   = 4;
  localparam int LEN_LSB = 20;
  localparam int LEN_W   = 8;
  localparam int IMM_LSB = 4;
  localparam int IMM_W   = 16;

  function automatic logic [OPC_W-1:0] hdr_opc(input logic [31:0] w);
    return w[OPC_LSB +: OPC_W];
  endfunction

  function automatic logic [LEN_W-1:0] hdr_len(input logic [31:0] w);
    return w[LEN_LSB +: LEN_W];
  endfunction

  function automatic logic [IMM_W-1:0] hdr_imm(input logic [31:0] w);
    return w[IMM_LSB +: IMM_W];
  endfunction

endpackage

// File: rtl/h_bdy_eng_dec_oreg.sv
// Micro-op output register: loads on demand, holds while the exe stage stalls,
// clears valid once consumed with nothing new behind it.
module h_bdy_eng_dec_oreg
  import h_pkg::*;
(
  input  logic        clk,
  input  logic        arst,
  input  logic        load,
  input  logic [1:0]  nx_kind,
  input  logic [3:0]  nx_opc,
  input  logic [31:0] nx_dat,
  input  logic        nx_last,
  input  logic        rdy,
  output logic        vld,
  output logic [1:0]  kind,
  output logic [3:0]  opc,
  output logic [31:0] dat,
  output logic        last
);

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      vld  <= 1'b0;
      kind <= UOP_HDR;
      opc  <= 4'd0;
      dat  <= 32'd0;
      last <= 1'b0;
    end else if (load) begin
      vld  <= 1'b1;
      kind <= nx_kind;
      opc  <= nx_opc;
      dat  <= nx_dat;
      last <= nx_last;
    end else if (rdy) begin
      vld <= 1'b0;
    end
  end

endmodule

// File: rtl/h_bdy_eng_dec.sv
// Engine command decoder: splits header/payload words into micro-ops for the
// exe stage, drains payload of illegal commands, keeps command/error counts.
//
// state      | meaning
// IDLE       | next accepted word is a header
// PAYLOAD    | forwarding cnt remaining beats as DATA
// DRAIN      | discarding cnt remaining beats of an illegal command
module h_bdy_eng_dec
  import h_pkg::*;
#(
  parameter logic [15:0] OPC_LEGAL_MASK = 16'h00FF
) (
  input  logic        clk,
  input  logic        arst,
  input  logic        in_vld,
  input  logic [31:0] in_w,
  output logic        in_rdy,
  output logic        uop_vld,
  output logic [1:0]  uop_kind,
  output logic [3:0]  uop_opc,
  output logic [31:0] uop_dat,
  output logic        uop_last,
  input  logic        uop_rdy,
  output logic [15:0] cnt_cmd,
  output logic [7:0]  cnt_err
);

  logic [1:0]  state;
  logic [7:0]  cnt;
  logic [3:0]  cur_opc;
  logic        acc;
  logic        load;
  logic        legal;
  logic [3:0]  opc;
  logic [7:0]  len;
  logic [15:0] imm;
  logic [1:0]  nx_kind;
  logic [3:0]  nx_opc;
  logic [31:0] nx_dat;
  logic        nx_last;

  assign opc   = hdr_opc(in_w);
  assign len   = hdr_len(in_w);
  assign imm   = hdr_imm(in_w);
  assign legal = OPC_LEGAL_MASK[opc];

  // drained beats never touch the output register, so DRAIN ignores back-pressure
  assign in_rdy = (state == ST_DRAIN) ? 1'b1 : (!uop_vld || uop_rdy);
  assign acc    = in_vld && in_rdy;
  assign load   = acc && (state != ST_DRAIN);

  always_comb begin
    nx_kind = UOP_HDR;
    nx_opc  = opc;
    nx_dat  = {16'd0, imm};
    nx_last = (len == 8'd0);
    if (state == ST_PAYLOAD) begin
      nx_kind = UOP_DATA;
      nx_opc  = cur_opc;
      nx_dat  = in_w;
      nx_last = (cnt == 8'd1);
    end else if (!legal) begin
      nx_kind = UOP_ERR;
      nx_dat  = in_w;
      nx_last = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state   <= ST_IDLE;
      cnt     <= 8'd0;
      cur_opc <= 4'd0;
      cnt_cmd <= 16'd0;
      cnt_err <= 8'd0;
    end else if (acc) begin
      case (state)
        ST_IDLE: begin
          if (legal) begin
            cnt_cmd <= cnt_cmd + 16'd1;
            cur_opc <= opc;
            if (len != 8'd0) begin
              cnt   <= len;
              state <= ST_PAYLOAD;
            end
          end else begin
            if (cnt_err != 8'hFF) cnt_err <= cnt_err + 8'd1;
            if (len != 8'd0) begin
              cnt   <= len;
              state <= ST_DRAIN;
            end
          end
        end
        ST_PAYLOAD, ST_DRAIN: begin
          // the <= 1 test keeps the down-counter from ever wrapping below zero
          if (cnt <= 8'd1) begin
            cnt   <= 8'd0;
            state <= ST_IDLE;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  h_bdy_eng_dec_oreg u_oreg (
    .clk     (clk),
    .arst    (arst),
    .load    (load),
    .nx_kind (nx_kind),
    .nx_opc  (nx_opc),
    .nx_dat  (nx_dat),
    .nx_last (nx_last),
    .rdy     (uop_rdy),
    .vld     (uop_vld),
    .kind    (uop_kind),
    .opc     (uop_opc),
    .dat     (uop_dat),
    .last    (uop_last)
  );

endmodule

// File: tb/tb_h_bdy_eng_dec.sv
// Directed bench for h_bdy_eng_dec: inputs change and outputs are sampled on
// the falling edge; expected micro-ops are hand-computed constants.
module tb_h_bdy_eng_dec;

  logic        clk = 1'b0;
  logic        arst;
  logic        in_vld;
  logic [31:0] in_w;
  logic        in_rdy;
  logic        uop_vld;
  logic [1:0]  uop_kind;
  logic [3:0]  uop_opc;
  logic [31:0] uop_dat;
  logic        uop_last;
  logic        uop_rdy;
  logic [15:0] cnt_cmd;
  logic [7:0]  cnt_err;

  int n_chk = 0;
  int n_err = 0;

  logic [38:0] fired[$];

  always #5 clk = ~clk;

  h_bdy_eng_dec #(.OPC_LEGAL_MASK(16'h00FF)) dut (
    .clk      (clk),
    .arst     (arst),
    .in_vld   (in_vld),
    .in_w     (in_w),
    .in_rdy   (in_rdy),
    .uop_vld  (uop_vld),
    .uop_kind (uop_kind),
    .uop_opc  (uop_opc),
    .uop_dat  (uop_dat),
    .uop_last (uop_last),
    .uop_rdy  (uop_rdy),
    .cnt_cmd  (cnt_cmd),
    .cnt_err  (cnt_err)
  );

  // every micro-op handed to the exe stage, as {kind, opc, last, dat}
  always @(posedge clk) begin
    if (!arst && uop_vld && uop_rdy) fired.push_back({uop_kind, uop_opc, uop_last, uop_dat});
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] want);
    n_chk++;
    if (act !== want) begin
      n_err++;
      $display("FAIL %s act=%0h want=%0h", tag, act, want);
    end
  endtask

  task automatic chk_uop(input string tag, input logic [1:0] kind, input logic [3:0] opc,
                         input logic [31:0] dat, input logic last);
    chk({tag, "_vld"}, {31'd0, uop_vld}, 32'd1);
    chk({tag, "_klo"}, {25'd0, uop_kind, uop_opc, uop_last}, {25'd0, kind, opc, last});
    chk({tag, "_dat"}, uop_dat, dat);
  endtask

  logic [31:0] w4[5];
  logic [38:0] snap;
  logic        stalled;
  int          idx;

  initial begin
    arst    = 1'b1;
    in_vld  = 1'b0;
    in_w    = 32'd0;
    uop_rdy = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_vld", {31'd0, uop_vld}, 32'd0);
    chk("rst_in_rdy", {31'd0, in_rdy}, 32'd1);
    chk("rst_klo", {25'd0, uop_kind, uop_opc, uop_last}, 32'd0);
    chk("rst_dat", uop_dat, 32'd0);
    chk("rst_cnt_cmd", {16'd0, cnt_cmd}, 32'd0);
    chk("rst_cnt_err", {24'd0, cnt_err}, 32'd0);
    arst = 1'b0;
    @(negedge clk);

    // legal header, 3 beats, full throughput
    in_vld = 1'b1;
    in_w   = 32'h103ABCD0;
    @(negedge clk);
    chk_uop("t1_hdr", 2'd0, 4'd1, 32'h0000ABCD, 1'b0);
    chk("t1_cnt_cmd", {16'd0, cnt_cmd}, 32'd1);
    in_w = 32'h11111111;
    @(negedge clk);
    chk_uop("t1_d1", 2'd1, 4'd1, 32'h11111111, 1'b0);
    in_w = 32'h22222222;
    @(negedge clk);
    chk_uop("t1_d2", 2'd1, 4'd1, 32'h22222222, 1'b0);
    in_w = 32'h33333333;
    @(negedge clk);
    chk_uop("t1_d3", 2'd1, 4'd1, 32'h33333333, 1'b1);
    in_vld = 1'b0;
    @(negedge clk);
    chk("t1_drained", {31'd0, uop_vld}, 32'd0);
    chk("t1_state", {30'd0, dut.state}, 32'd0);

    // len 0 legal header
    in_vld = 1'b1;
    in_w   = 32'h20001230;
    @(negedge clk);
    in_vld = 1'b0;
    chk_uop("t2_hdr", 2'd0, 4'd2, 32'h00000123, 1'b1);
    chk("t2_state", {30'd0, dut.state}, 32'd0);
    chk("t2_cnt_cmd", {16'd0, cnt_cmd}, 32'd2);
    @(negedge clk);

    // illegal header with 2 beats while exe stalls
    uop_rdy = 1'b0;
    fired.delete();
    in_vld = 1'b1;
    in_w   = 32'h90200000;
    @(negedge clk);
    chk_uop("t3_err", 2'd2, 4'd9, 32'h90200000, 1'b1);
    chk("t3_cnt_err", {24'd0, cnt_err}, 32'd1);
    in_w = 32'hDEAD0001;
    #1 chk("t3_rdy1", {31'd0, in_rdy}, 32'd1);
    @(negedge clk);
    chk_uop("t3_hold1", 2'd2, 4'd9, 32'h90200000, 1'b1);
    in_w = 32'hDEAD0002;
    #1 chk("t3_rdy2", {31'd0, in_rdy}, 32'd1);
    @(negedge clk);
    chk_uop("t3_hold2", 2'd2, 4'd9, 32'h90200000, 1'b1);
    chk("t3_state", {30'd0, dut.state}, 32'd0);
    in_vld = 1'b0;
    #1 chk("t3_rdy_blocked", {31'd0, in_rdy}, 32'd0);
    uop_rdy = 1'b1;
    #1 chk("t3_rdy_open", {31'd0, in_rdy}, 32'd1);
    @(negedge clk);
    chk("t3_drained", {31'd0, uop_vld}, 32'd0);
    chk("t3_fires", fired.size(), 32'd1);

    // 4-beat payload with exe ready toggling 1010...
    fired.delete();
    w4[0] = 32'h40400550;
    w4[1] = 32'hA0000001;
    w4[2] = 32'hA0000002;
    w4[3] = 32'hA0000003;
    w4[4] = 32'hA0000004;
    idx     = 0;
    stalled = 1'b0;
    snap    = '0;
    for (int c = 0; c < 40; c++) begin
      if (idx == 5 && !uop_vld) break;
      if (stalled) begin
        chk("t4_stable_dat", uop_dat, snap[31:0]);
        chk("t4_stable_klo", {25'd0, uop_kind, uop_opc, uop_last}, {25'd0, snap[38:32]});
      end
      uop_rdy = (c % 2 == 0);
      in_vld  = (idx < 5);
      if (idx < 5) in_w = w4[idx];
      #1;
      stalled = uop_vld && !uop_rdy;
      snap    = {uop_kind, uop_opc, uop_last, uop_dat};
      if (in_vld && in_rdy) idx++;
      @(negedge clk);
    end
    in_vld  = 1'b0;
    uop_rdy = 1'b1;
    chk("t4_words_sent", idx, 32'd5);
    chk("t4_fires", fired.size(), 32'd5);
    for (int i = 0; i < 5; i++) begin
      if (i < fired.size()) begin
        chk($sformatf("t4_klo%0d", i), {25'd0, fired[i][38:32]},
            (i == 0) ? {25'd0, 2'd0, 4'd4, 1'b0} : {25'd0, 2'd1, 4'd4, (i == 4)});
        chk($sformatf("t4_dat%0d", i), fired[i][31:0], (i == 0) ? 32'h00000055 : w4[i]);
      end
    end
    @(negedge clk);

    // error counter saturation
    arst = 1'b1;
    @(negedge clk);
    arst   = 1'b0;
    in_w   = 32'hF0000000;
    in_vld = 1'b1;
    repeat (255) @(negedge clk);
    chk("t5_err_255", {24'd0, cnt_err}, 32'd255);
    @(negedge clk);
    chk("t5_err_sat", {24'd0, cnt_err}, 32'd255);
    chk("t5_cmd_zero", {16'd0, cnt_cmd}, 32'd0);
    in_vld = 1'b0;

    // command counter wrap
    arst = 1'b1;
    @(negedge clk);
    arst   = 1'b0;
    in_w   = 32'h00000000;
    in_vld = 1'b1;
    repeat (65535) @(negedge clk);
    chk("t5_cmd_ffff", {16'd0, cnt_cmd}, 32'h0000FFFF);
    @(negedge clk);
    chk("t5_cmd_wrap", {16'd0, cnt_cmd}, 32'd0);
    in_vld = 1'b0;
    @(negedge clk);

    // reset in the middle of a len-5 command
    in_vld = 1'b1;
    in_w   = 32'h50500000;
    @(negedge clk);
    in_w = 32'hB0000001;
    @(negedge clk);
    chk_uop("t6_d1", 2'd1, 4'd5, 32'hB0000001, 1'b0);
    in_vld = 1'b0;
    arst   = 1'b1;
    #1;
    chk("t6_rst_vld", {31'd0, uop_vld}, 32'd0);
    chk("t6_rst_in_rdy", {31'd0, in_rdy}, 32'd1);
    chk("t6_rst_state", {30'd0, dut.state}, 32'd0);
    @(negedge clk);
    arst   = 1'b0;
    in_vld = 1'b1;
    in_w   = 32'h60007770;
    @(negedge clk);
    in_vld = 1'b0;
    chk_uop("t6_hdr", 2'd0, 4'd6, 32'h00000777, 1'b1);
    chk("t6_cnt_cmd", {16'd0, cnt_cmd}, 32'd1);
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/h_bdy_eng_dec.md
H_BDY_ENG_DEC -- requirements
Module: h_bdy_eng_dec

Interface
REQ-001 SHALL have parameter OPC_LEGAL_MASK, default 16'h00FF; bit n set means opcode n is legal.
REQ-002 SHALL have port clk, input, 1, the single clock; all state SHALL be clocked on its rising edge.
REQ-003 SHALL have port arst, input, 1, asynchronous active-high reset.
REQ-004 SHALL have port in_vld, input, 1, command word valid.
REQ-005 SHALL have port in_w, input, 32, command word: header = {opc[31:28], len[27:20], imm[19:4], rsvd[3:0]}, or payload beat.
REQ-006 SHALL have port in_rdy, output, 1, word accepted when in_vld && in_rdy.
REQ-007 SHALL have port uop_vld, output, 1, micro-op valid toward h_bdy_eng_exe.
REQ-008 SHALL have port uop_kind, output, 2, micro-op kind: 0 HDR, 1 DATA, 2 ERR.
REQ-009 SHALL have port uop_opc, output, 4, opcode of the owning command.
REQ-010 SHALL have port uop_dat, output, 32, {16'b0, imm} for HDR, beat for DATA, raw header for ERR.
REQ-011 SHALL have port uop_last, output, 1, final micro-op of the command.
REQ-012 SHALL have port uop_rdy, input, 1, exe stage accepts when uop_vld && uop_rdy.
REQ-013 SHALL have port cnt_cmd, output, 16, count of legal headers accepted; wraps.
REQ-014 SHALL have port cnt_err, output, 8, count of illegal headers accepted; saturates at 255.

Function
REQ-015 SHALL implement FSM states IDLE (expect header), PAYLOAD (forward beats), DRAIN (discard beats).
REQ-016 SHALL register every micro-op in a single output register, one cycle of latency from input acceptance to uop_vld.
REQ-017 SHALL drive in_rdy = !uop_vld || uop_rdy in IDLE and PAYLOAD, giving full throughput.
REQ-018 SHALL drive in_rdy = 1 in DRAIN regardless of uop_rdy; drained beats SHALL produce no micro-op.
REQ-019 SHALL hold uop_* stable while uop_vld && !uop_rdy.
REQ-020 SHALL, on a legal header accepted in IDLE, emit HDR; if len == 0, set uop_last = 1 and remain IDLE; otherwise load an 8-bit down-counter with len and enter PAYLOAD.
REQ-021 SHALL, in PAYLOAD, emit DATA per accepted beat, decrementing the counter; on the beat with counter == 1, set uop_last = 1 and return to IDLE.
REQ-022 SHALL, on an illegal header (OPC_LEGAL_MASK[opc] == 0), emit ERR with uop_last = 1; if len > 0, enter DRAIN with the counter = len; otherwise remain IDLE.
REQ-023 SHALL, in DRAIN, return to IDLE after the len-th discarded beat; the counter SHALL never underflow.
REQ-024 SHALL increment cnt_cmd on the acceptance cycle of each legal header, with 16'hFFFF + 1 -> 0.
REQ-025 SHALL increment cnt_err on each illegal header, holding at 8'hFF.
REQ-026 SHALL ignore rsvd bits.
REQ-027 SHALL allow a new input to be accepted in the same cycle as the output register drains.

Reset
REQ-028 SHALL, while arst is high, force state = IDLE, counter = 0, uop_vld = 0, uop_kind/uop_opc/uop_dat/uop_last = 0, cnt_cmd = 0, cnt_err = 0, and in_rdy = 1.
REQ-029 SHALL, on reset mid-command, discard the partial command and any pending micro-op; the first word after reset SHALL be treated as a header.

Structure
REQ-030 SHALL place the uop kind enum, header field positions/widths and the FSM state enum in h_pkg.
REQ-031 SHALL implement the output register as the sub-module h_bdy_eng_dec_oreg (valid/hold register); the FSM and counters SHALL live in the top module.

Verification
REQ-032 Bench SHALL cover: header 0x1_03_ABCD_0, then 3 beats, with uop_rdy = 1 -> HDR(opc 1, dat 0xABCD), DATA x3 with last on the 3rd, cnt_cmd = 1, one uop per cycle.
REQ-033 Bench SHALL cover: header opc 2, len 0 -> single HDR with last = 1, state remains IDLE.
REQ-034 Bench SHALL cover: illegal opc 9, len 2, followed by 2 beats while uop_rdy = 0 -> one ERR pending, both beats absorbed (in_rdy = 1), cnt_err = 1, no DATA uops.
REQ-035 Bench SHALL cover: uop_rdy toggling 1010... during a 4-beat payload -> no loss or duplication, uop_* stable while stalled.
REQ-036 Bench SHALL cover: 256 illegal headers -> cnt_err = 255; 65536 legal len-0 headers -> cnt_cmd wraps to 0.
REQ-037 Bench SHALL cover: arst asserted after beat 1 of a len-5 command -> uop_vld = 0 immediately; the next word is decoded as a header.
